// File: rtl/clock_div_ctrl.sv
// Synchronous, glitch-free clock divider: square wave of period 2^(cur_sel+1) clocks plus an end-of-period tick.
// Ratio changes and stops are deferred to a period boundary so no runt pulse is ever produced.
module clock_div_ctrl #(
  parameter int MAX_SEL     = 16,
  parameter int DEFAULT_SEL = 16,
  parameter int SEL_W       = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             div_clock,
  output logic             tick,
  output logic             busy,
  output logic [SEL_W-1:0] cur_sel,
  output logic [1:0]       state_o
);

  localparam int CNT_W = MAX_SEL + 1;

  // Handshake: a configuration transfers on any rising edge where cfg_valid && cfg_ready;
  // cfg_ready depends only on registered state, and cfg_sel must be stable while cfg_valid is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic               div_clock_q, div_clock_d;
  logic               tick_q, tick_d;
  logic               accept;
  logic               at_term;
  logic               running_d;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if (s > SEL_W'(MAX_SEL)) return SEL_W'(MAX_SEL);
    return s;
  endfunction

  // Terminal count 2^(s+1)-1 as a right-shifted all-ones mask of the counter width.
  function automatic logic [CNT_W-1:0] term_cnt(input logic [SEL_W-1:0] s);
    return {CNT_W{1'b1}} >> (SEL_W'(MAX_SEL) - s);
  endfunction

  assign cfg_ready = (state_q != PEND);
  assign accept    = cfg_valid && cfg_ready;
  assign at_term   = (cnt_q == term_cnt(cur_sel_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) cur_sel_d = clamp_sel(cfg_sel);
        if (enable) state_d = RUN;
      end
      RUN: begin
        cnt_d = at_term ? '0 : cnt_q + 1'b1;
        if (accept) begin
          pend_sel_d = clamp_sel(cfg_sel);
          state_d    = PEND;
        end else if (at_term && !enable) begin
          state_d = IDLE;
        end
      end
      PEND: begin
        cnt_d = at_term ? '0 : cnt_q + 1'b1;
        if (at_term) begin
          cur_sel_d = pend_sel_q;
          state_d   = enable ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are precomputed from next-state so they leave flops directly and cannot glitch on a ratio change.
  always_comb begin
    running_d   = (state_d != IDLE);
    div_clock_d = running_d && (|(cnt_d & (CNT_W'(1) << cur_sel_d)));
    tick_d      = running_d && (cnt_d == term_cnt(cur_sel_d));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_sel_q   <= SEL_W'(DEFAULT_SEL);
      pend_sel_q  <= '0;
      div_clock_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      div_clock_q <= div_clock_d;
      tick_q      <= tick_d;
    end
  end

  assign div_clock = div_clock_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);
  assign cur_sel   = cur_sel_q;
  assign state_o   = state_q;

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Synchronous, glitch-free replacement and controller for the ripple clock divider.
- Produces `div_clock`, a square wave of period 2^(cur_sel+1) input clocks, and a one-cycle `tick` enable at the end of each period.
- Software/FSM logic selects the divide ratio through a valid/ready handshake.
- Ratio changes and stops take effect only at a period boundary, so downstream logic never sees a runt pulse.

Parameters:
- MAX_SEL, 16: largest legal divide exponent; the counter is MAX_SEL+1 bits wide.
- DEFAULT_SEL, 16: exponent loaded at reset (divide by 2^17).
- SEL_W, 5: width of the select fields; must satisfy 2^SEL_W > MAX_SEL.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level request to run the divider.
- cfg_valid  input  1  new exponent offered on cfg_sel.
- cfg_sel  input  SEL_W  requested exponent; divide ratio = 2^(cfg_sel+1).
- cfg_ready  output  1  block can accept a configuration this cycle.
- div_clock  output  1  divided clock, 50% duty.
- tick  output  1  one-cycle pulse on the last cycle of each period.
- busy  output  1  divider running (state != IDLE).
- cur_sel  output  SEL_W  exponent currently in effect.

Behaviour:
- Reset (reset=0, asynchronous, immediate, including mid-operation):
  - state=IDLE, cnt=0, pend_sel=0, cur_sel=DEFAULT_SEL.
  - Outputs: div_clock=0, tick=0, busy=0, cfg_ready=1.
- Clamp: any accepted cfg_sel > MAX_SEL is clamped to MAX_SEL.
- Counter and terminal count:
  - cnt counts 0 .. T, where T = 2^(cur_sel+1)-1.
  - It increments by 1 per clock in RUN/PEND and wraps T -> 0.
- div_clock = cnt[cur_sel], decoded from the registered counter.
  - Low for the first 2^cur_sel cycles of a period, high for the next 2^cur_sel.
  - Forced 0 in IDLE.
- tick = 1 exactly when state is RUN or PEND and cnt==T; 0 otherwise.
- Config handshake: accepted on a cycle where cfg_valid && cfg_ready.
- State IDLE:
  - cnt held at 0; cfg_ready=1.
  - An accepted config loads cur_sel on the next edge.
  - enable=1 -> RUN on the next edge; cnt=0 in the first RUN cycle.
  - Config accepted in the same cycle as enable: RUN starts with the new cur_sel.
- State RUN:
  - cfg_ready=1.
  - Accepted config -> store pend_sel, go to PEND; cur_sel is unchanged.
  - cnt==T and enable==0 -> IDLE (clean stop after a full period; div_clock ends low).
  - An enable drop mid-period is ignored until cnt==T.
- State PEND:
  - cfg_ready=0; cnt keeps counting with the old cur_sel.
  - At cnt==T: cur_sel<=pend_sel, cnt<=0.
  - Next state is RUN if enable=1, else IDLE.
  - tick still pulses on this final old-ratio cycle.
- Boundary conditions:
  - Config accepted on the very cycle cnt==T in RUN: enter PEND; the new ratio applies at the end of the following old-ratio period (the current T is not re-used).
  - cur_sel=0: period 2, div_clock toggles every cycle, tick every other cycle.
  - cur_sel=MAX_SEL: cnt uses all MAX_SEL+1 bits; wrap from all-ones to 0 with no overflow flag.
- busy=1 in RUN and PEND.
- Outputs are derived only from registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset with cfg_sel=2 accepted in IDLE, then enable=1 -> cur_sel=2; div_clock pattern 0000 1111 repeating; tick on cycles 8, 16, 24 after RUN entry; busy=1.
- Running at sel=2, offer cfg_sel=0 at cnt=3 -> cfg_ready drops; the old 8-cycle period completes with tick at cnt=7; then div_clock toggles every cycle, tick every 2 cycles; cfg_ready returns to 1.
- Running at sel=1, drop enable at cnt=1 -> counting continues to cnt=3, tick pulses, then IDLE with div_clock=0, busy=0, cnt=0.
- Offer cfg_sel=31 with MAX_SEL=16 -> cur_sel=16; period 131072 cycles; tick once per period; cnt wraps to 0.
- Assert reset low while in PEND at cnt=5 -> immediately state=IDLE, cur_sel=16, div_clock=0, tick=0, cfg_ready=1; the pending select is discarded.
- Set cfg_valid=1 with cfg_sel=3 and enable=1 in the same IDLE cycle -> RUN starts at sel=3, first tick 16 cycles later.
